// File: rtl/ccc_lock_reset_seq.sv
// Fabric reset sequencer behind the CCC: waits for lock to be stable, holds reset
// for a fixed period, then releases; counts and flags lock losses seen while running.
module ccc_lock_reset_seq #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned HOLD_CYCLES   = 8,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned LOSS_W        = 8
) (
  input  logic              PCLK,
  input  logic              PRESERN,
  input  logic              LOCK_IN,
  input  logic              SW_RESET,
  input  logic              CLR_LOSS,
  output logic              FAB_RESETN,
  output logic              READY,
  output logic [1:0]        STATE,
  output logic [LOSS_W-1:0] LOSS_COUNT,
  output logic              LOSS_IRQ
);

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_STAB = 2'd1,
    S_HOLD = 2'd2,
    S_RUN  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          sync_q;
  logic [LOSS_W-1:0]   loss_q, loss_d;
  logic                fab_q, irq_q;
  logic                lock_s, loss_inc;

  assign lock_s = sync_q[1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    loss_inc = 1'b0;
    case (state_q)
      S_WAIT: begin
        cnt_d = '0;
        if (lock_s) state_d = S_STAB;
      end
      S_STAB: begin
        if (!lock_s) state_d = S_WAIT;
        else if (cnt_q == STAB_LAST) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      S_HOLD: begin
        if (!lock_s) state_d = S_WAIT;
        else if (cnt_q == HOLD_LAST) state_d = S_RUN;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      S_RUN: begin
        // a loss outranks a simultaneous firmware re-hold request
        if (!lock_s) begin
          state_d  = S_WAIT;
          loss_inc = 1'b1;
        end else if (SW_RESET) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_comb begin
    loss_d = loss_q;
    if (CLR_LOSS)                    loss_d = LOSS_W'(loss_inc);
    else if (loss_inc && loss_q != '1) loss_d = loss_q + LOSS_W'(1);
  end

  always_ff @(posedge PCLK) begin
    if (!PRESERN) begin
      sync_q  <= '0;
      state_q <= S_WAIT;
      cnt_q   <= '0;
      loss_q  <= '0;
      fab_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], LOCK_IN};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      loss_q  <= loss_d;
      fab_q   <= (state_d == S_RUN);
      irq_q   <= loss_inc;
    end
  end

  // READY mirrors the released condition so it reads 0 out of reset
  assign FAB_RESETN = fab_q;
  assign READY      = fab_q;
  assign STATE      = state_q;
  assign LOSS_COUNT = loss_q;
  assign LOSS_IRQ   = irq_q;

endmodule
